// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller:
// FSM state encoding, registered control bundle and its decoder.
package mips_pipe_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_STALL  = 2'd1,
        MULTI_STALL = 2'd2,
        BR_FLUSH    = 2'd3
    } hazard_state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic busy;
    } hazard_ctrl_t;

    // While reset is held every stage is bubbled and nothing advances
    localparam hazard_ctrl_t CTRL_RESET = hazard_ctrl_t'(7'b000_111_0);
    localparam hazard_ctrl_t CTRL_RUN   = hazard_ctrl_t'(7'b111_000_0);
    localparam hazard_ctrl_t CTRL_LOAD  = hazard_ctrl_t'(7'b001_010_0);
    localparam hazard_ctrl_t CTRL_MULTI = hazard_ctrl_t'(7'b000_001_1);
    localparam hazard_ctrl_t CTRL_BR    = hazard_ctrl_t'(7'b111_110_0);

    function automatic hazard_ctrl_t decode_ctrl(input hazard_state_t st, input logic jump_flush);
        hazard_ctrl_t c;
        c = CTRL_RUN;
        case (st)
            LOAD_STALL:  c = CTRL_LOAD;
            MULTI_STALL: c = CTRL_MULTI;
            BR_FLUSH:    c = CTRL_BR;
            default:     c.flush_ifid = jump_flush;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detection inputs from the pipeline and register control outputs.
// The pipeline side uses the master modport, the controller the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = mips_pipe_pkg::REG_AW,
    parameter int CNT_W  = 3
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              idex_memread;
    logic [REG_AW-1:0] idex_rt;
    logic              ex_branch_taken;
    logic              id_jump;
    logic              ex_multi_start;
    logic [CNT_W-1:0]  ex_multi_cycles;

    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
    logic busy;

    modport master (
        output id_rs, id_rt, idex_memread, idex_rt, ex_branch_taken,
               id_jump, ex_multi_start, ex_multi_cycles,
        input  pc_write, ifid_write, idex_write, flush_ifid, flush_idex,
               flush_exmem, busy
    );

    modport slave (
        input  id_rs, id_rt, idex_memread, idex_rt, ex_branch_taken,
               id_jump, ex_multi_start, ex_multi_cycles,
        output pc_write, ifid_write, idex_write, flush_ifid, flush_idex,
               flush_exmem, busy
    );
endinterface

// File: rtl/hazard_stat_counter.sv
// Saturating 16-bit event counter with increment enable, cleared by reset.
module hazard_stat_counter
    import mips_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && count != STAT_MAX)
            count <= count + 16'd1;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decides hold/load/flush for PC, IF/ID, ID/EX, EX/MEM.
// Define HAZARD_STATS_EN to add the stall_cycles / flush_events statistics outputs.
module pipe_hazard_ctrl #(
    parameter int REG_AW = mips_pipe_pkg::REG_AW,
    parameter int CNT_W  = 3
) (
    input  logic clk,
    input  logic rst_n,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);
    import mips_pipe_pkg::*;

    hazard_state_t    state;
    hazard_state_t    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_use;
    logic             jump_flush;
    hazard_ctrl_t     ctrl;
    hazard_ctrl_t     ctrl_nxt;

    // Events are only accepted in RUN; priority branch > multi > load-use > jump
    always_comb begin
        load_use   = hz.idex_memread && (hz.idex_rt != REG_AW'(REG_ZERO)) &&
                     ((hz.idex_rt == hz.id_rs) || (hz.idex_rt == hz.id_rt));
        state_nxt  = RUN;
        cnt_nxt    = cnt;
        jump_flush = 1'b0;
        case (state)
            RUN: begin
                if (hz.ex_branch_taken)
                    state_nxt = BR_FLUSH;
                else if (hz.ex_multi_start) begin
                    state_nxt = MULTI_STALL;
                    cnt_nxt   = (hz.ex_multi_cycles == '0) ? CNT_W'(1) : hz.ex_multi_cycles;
                end
                else if (load_use)
                    state_nxt = LOAD_STALL;
                else
                    jump_flush = hz.id_jump;
            end
            MULTI_STALL: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt > CNT_W'(1))
                    state_nxt = MULTI_STALL;
            end
            default: state_nxt = RUN;
        endcase
        ctrl_nxt = decode_ctrl(state_nxt, jump_flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            ctrl  <= CTRL_RESET;
        end
        else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ctrl  <= ctrl_nxt;
        end
    end

    assign hz.pc_write    = ctrl.pc_write;
    assign hz.ifid_write  = ctrl.ifid_write;
    assign hz.idex_write  = ctrl.idex_write;
    assign hz.flush_ifid  = ctrl.flush_ifid;
    assign hz.flush_idex  = ctrl.flush_idex;
    assign hz.flush_exmem = ctrl.flush_exmem;
    assign hz.busy        = ctrl.busy;

`ifdef HAZARD_STATS_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (state == LOAD_STALL) || (state == MULTI_STALL);
    assign flush_inc = (state == RUN) && ((state_nxt == BR_FLUSH) || jump_flush);

    hazard_stat_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    hazard_stat_counter u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_events)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard testbench for pipe_hazard_ctrl: directed per-cycle vectors push
// expected control words; a monitor pops and compares after every posedge.
module tb_pipe_hazard_ctrl;

    // {pc_write, ifid_write, idex_write, flush_ifid, flush_idex, flush_exmem, busy}
    localparam logic [6:0] E_RST = 7'b000_111_0;
    localparam logic [6:0] E_RUN = 7'b111_000_0;
    localparam logic [6:0] E_JMP = 7'b111_100_0;
    localparam logic [6:0] E_LDS = 7'b001_010_0;
    localparam logic [6:0] E_MUL = 7'b000_001_1;
    localparam logic [6:0] E_BRF = 7'b111_110_0;

    typedef struct {
        logic [6:0] exp;
        string      name;
    } sb_item_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    sb_item_t exp_q[$];

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(3)) hz ();

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {hz.pc_write, hz.ifid_write, hz.idex_write, hz.flush_ifid,
               hz.flush_idex, hz.flush_exmem, hz.busy};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // One cycle of stimulus, driven half a cycle before the sampling posedge
    task automatic applyStimulus(input logic rstn, input logic mr, input logic [4:0] ld_rt,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic br,
                                 input logic jmp, input logic ms, input logic [2:0] mc,
                                 input logic [6:0] exp, input string name);
        sb_item_t it;
        @(negedge clk);
        #1;
        rst_n              = rstn;
        hz.idex_memread    = mr;
        hz.idex_rt         = ld_rt;
        hz.id_rs           = rs;
        hz.id_rt           = rt;
        hz.ex_branch_taken = br;
        hz.id_jump         = jmp;
        hz.ex_multi_start  = ms;
        hz.ex_multi_cycles = mc;
        it.exp  = exp;
        it.name = name;
        exp_q.push_back(it);
    endtask

    task automatic applyIdle(input logic [6:0] exp, input string name);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, exp, name);
    endtask

    initial begin
        sb_item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                checkOutput(it.name, it.exp);
            end
        end
    end

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst_n              = 1'b0;
        hz.idex_memread    = 1'b0;
        hz.idex_rt         = '0;
        hz.id_rs           = '0;
        hz.id_rt           = '0;
        hz.ex_branch_taken = 1'b0;
        hz.id_jump         = 1'b0;
        hz.ex_multi_start  = 1'b0;
        hz.ex_multi_cycles = '0;

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, E_RST, "reset_hold");
        applyIdle(E_RUN, "reset_release");
        applyIdle(E_RUN, "run_idle");

        // Load-use on rs, on rt, and the non-stalling cases
        applyStimulus(1'b1, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 3'd0, E_LDS, "load_use_rs");
        applyIdle(E_RUN, "after_load_use_rs");
        applyStimulus(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 3'd0, E_LDS, "load_use_rt");
        applyIdle(E_RUN, "after_load_use_rt");
        applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, E_RUN, "load_reg_zero");
        applyStimulus(1'b1, 1'b1, 5'd8, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0, 3'd0, E_RUN, "load_no_match");

        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, E_JMP, "jump");
        applyIdle(E_RUN, "after_jump");

        // Multi-cycle stall of 3 with a branch pulse that must be ignored
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd3, E_MUL, "multi3_c1");
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, E_MUL, "multi3_c2_branch");
        applyIdle(E_MUL, "multi3_c3");
        applyIdle(E_RUN, "multi3_done");
        applyIdle(E_RUN, "multi3_no_late_branch");

        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd0, E_MUL, "multi0_c1");
        applyIdle(E_RUN, "multi0_done");

        // Priority resolution
        applyStimulus(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0, E_BRF, "prio_branch");
        applyIdle(E_RUN, "prio_branch_done");
        applyStimulus(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 3'd1, E_MUL, "prio_multi");
        applyIdle(E_RUN, "prio_multi_done");
        applyStimulus(1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 3'd0, E_LDS, "prio_load_over_jump");
        applyIdle(E_RUN, "prio_load_done");

        // Reset pulsed during the second cycle of a 5-cycle multi stall
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd5, E_MUL, "multi5_c1");
        applyIdle(E_MUL, "multi5_c2");
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, E_RST, "mid_stall_reset_hold");
        #1;
        checkOutput("mid_stall_reset_async", E_RST);
        applyIdle(E_RUN, "mid_stall_release");
        applyIdle(E_RUN, "mid_stall_no_resume");

        // Two load-use stalls and one jump
        applyStimulus(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, E_LDS, "stats_lds1");
        applyIdle(E_RUN, "stats_run1");
        applyStimulus(1'b1, 1'b1, 5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 3'd0, E_LDS, "stats_lds2");
        applyIdle(E_RUN, "stats_run2");
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, E_JMP, "stats_jump");
        applyIdle(E_RUN, "stats_run3");

        @(posedge clk);
        #2;
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

`ifdef HAZARD_STATS_EN
        vectors++;
        if (stall_cycles !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL stall_cycles: got %0d expected 2", stall_cycles);
        end
        vectors++;
        if (flush_events !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL flush_events: got %0d expected 1", flush_events);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard controller for the multicycle MIPS pipeline. Each cycle it decides whether every pipeline register holds, loads, or flushes:
- detects load-use hazards, taken branches, jumps and multi-cycle EX operations;
- drives the write-enable and `FlushRegisters` inputs of the IF/ID, ID/EX and EX/MEM delay registers.

It sits beside the pipeline registers. It updates on the rising edge so that its controls are stable before the registers capture on the falling edge.

## Interface
Parameters:
- `REG_AW`, 5 — register-address width.
- `CNT_W`, 3 — width of the multi-cycle stall counter.

Ports:
- `clk` — in, 1 — clock; controller state updates on posedge.
- `rst_n` — in, 1 — reset, asynchronous, active-low.
- `id_rs`, `id_rt` — in, `REG_AW` — source registers of the instruction in ID.
- `idex_memread` — in, 1 — the instruction in EX is a load.
- `idex_rt` — in, `REG_AW` — destination of that load.
- `ex_branch_taken` — in, 1 — branch resolved taken in EX.
- `id_jump` — in, 1 — jump decoded in ID.
- `ex_multi_start` — in, 1 — a multi-cycle operation (mult/div) enters EX.
- `ex_multi_cycles` — in, `CNT_W` — number of extra EX cycles required.
- `pc_write`, `ifid_write`, `idex_write` — out, 1 each — register load enables.
- `flush_ifid`, `flush_idex`, `flush_exmem` — out, 1 each — drive the `FlushRegisters` inputs.
- `busy` — out, 1 — a multi-cycle stall is in progress.

## Operation
- **States:** RUN, LOAD_STALL, MULTI_STALL, BR_FLUSH. All outputs are registered and decoded from the next state.
- **Event priority in RUN:** branch > multi > load-use > jump. Lower-priority events sampled in the same cycle are dropped.
- **Branch:** `ex_branch_taken` → BR_FLUSH for 1 cycle.
  - `flush_ifid=1`, `flush_idex=1`, all writes =1 (PC loads the target).
  - Then RUN.
- **Multi-cycle:** `ex_multi_start` → MULTI_STALL.
  - Counter loads `ex_multi_cycles`; the value 0 is treated as 1.
  - Outputs: `pc_write=ifid_write=idex_write=0`, `flush_exmem=1`, `busy=1`.
  - Counter decrements each cycle; leaves to RUN after the cycle in which it reaches 0.
  - All other inputs are ignored while in MULTI_STALL.
- **Load-use:** `idex_memread && idex_rt!=0 && (idex_rt==id_rs || idex_rt==id_rt)` → LOAD_STALL for 1 cycle.
  - `pc_write=ifid_write=0`, `flush_idex=1`, `idex_write=1`.
  - Then RUN, which re-evaluates: back-to-back hazards stall again.
- **Jump:** `id_jump` → stay in RUN; `flush_ifid=1` for that cycle only.
- **RUN default:** all writes =1, all flushes =0, `busy=0`.
- **Reset values (held while `rst_n=0`):**
  - state RUN, counter 0;
  - `pc_write=ifid_write=idex_write=0`;
  - `flush_ifid=flush_idex=flush_exmem=1` (pipeline is bubbled during reset);
  - `busy=0`.
- **Reset mid-stall:** aborts immediately to the reset values; no stall resumes afterwards.
- **Register $zero:** a load targeting register 0 never causes a stall.

## Timing
- Inputs are sampled at posedge k. Outputs change at posedge k and are consumed by the pipeline registers at negedge k (half-cycle decision latency).
- Stall lengths:
  - load-use stall: exactly 1 cycle;
  - branch flush: exactly 1 cycle;
  - multi stall: `max(ex_multi_cycles,1)` cycles.
- The cycle after any stall state is RUN, with events evaluated normally.
- Asynchronous reset assertion forces the outputs within the same cycle. Deassertion takes effect at the next posedge.

## Configuration
- `HAZARD_STATS_EN` defined adds:
  - output `stall_cycles` (16 bit): counts cycles in LOAD_STALL or MULTI_STALL;
  - output `flush_events` (16 bit): counts entries to BR_FLUSH plus jump flushes.
  - Both counters saturate at 0xFFFF and clear on reset.
- `HAZARD_STATS_EN` undefined: these ports and counters do not exist. Core behaviour is identical in both builds.

## Structure
- Shared package `mips_pipe_pkg` holds:
  - the state enum;
  - `REG_AW`;
  - the register-0 constant;
  - the saturating counter max.
- The statistics logic is one sub-module, `hazard_stat_counter`: a saturating 16-bit counter with increment enable. It is instantiated twice, only under `HAZARD_STATS_EN`.

## Test plan
- **Reset:** `rst_n=0` for 3 cycles → flushes=1, writes=0, `busy=0`. Release → RUN outputs at the next posedge.
- **Load-use:** `idex_memread=1`, `idex_rt=8`, `id_rs=8` → 1 cycle of `pc_write=0`, `flush_idex=1`, then RUN. Repeat with `idex_rt=0` → no stall.
- **Multi-cycle:** `ex_multi_start=1`, `ex_multi_cycles=3` → `busy=1`, `flush_exmem=1` for 3 cycles. A `ex_branch_taken` pulse mid-stall is ignored.
- **Priority:** branch + load-use + jump in the same cycle → only BR_FLUSH (`flush_ifid=flush_idex=1`), no stall.
- **Reset mid-stall:** `ex_multi_cycles=5`; `rst_n` pulsed low in the 2nd stall cycle → reset values immediately, RUN after release, `busy=0`.
- **With `HAZARD_STATS_EN`:** 2 load-use stalls + 1 jump → `stall_cycles=2`, `flush_events=1`.
